// File: rtl/shift_serializer_tx_if.sv
// rtl/shift_serializer_tx_if.sv - word handshake bundle feeding shift_serializer_tx
`timescale 1ns/1ps

interface shift_serializer_tx_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] in_data;
    logic             in_lsb_first;
    logic             in_valid;
    logic             in_ready;

    // Word source side
    modport master (
        output in_data,
        output in_lsb_first,
        output in_valid,
        input  in_ready
    );

    // Serializer side
    modport slave (
        input  in_data,
        input  in_lsb_first,
        input  in_valid,
        output in_ready
    );
endinterface

// File: rtl/shift_serializer_tx.sv
// rtl/shift_serializer_tx.sv - parallel-to-serial transmitter, optional even parity bit under PARITY_EN
`timescale 1ns/1ps

module shift_serializer_tx #(
    parameter int   WIDTH      = 8,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    shift_serializer_tx_if.slave  in_if,
    output logic                  ser_out,
    output logic                  ser_en,
    output logic                  ser_last,
    output logic                  busy,
    output logic                  ser_par
);

`ifdef PARITY_EN
    localparam int FRAME_LEN = WIDTH + 1;
`else
    localparam int FRAME_LEN = WIDTH;
`endif
    localparam int CW = $clog2(FRAME_LEN);

    typedef enum logic {
        S_IDLE,
        S_SHIFT
    } state_t;

    state_t           state;
    logic             hold_full;
    logic [WIDTH-1:0] hold_data;
    logic             hold_lsb;
    logic [WIDTH-1:0] shreg;
    logic             sh_lsb;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_nxt;
    logic             load_now;
    logic             take;

    // ser_last is registered and marks the final bit cycle, so it doubles as the end-of-frame flag
    assign load_now       = hold_full && ((state == S_IDLE) || ser_last);
    assign in_if.in_ready = !hold_full || load_now;
    assign take           = in_if.in_valid && in_if.in_ready;
    assign busy           = (state == S_SHIFT) || hold_full;
    assign cnt_nxt        = cnt + 1'b1;

`ifdef PARITY_EN
    logic par_bit;

    // Frame sequencer with parity cycle appended after the data bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            hold_full <= 1'b0;
            hold_data <= '0;
            hold_lsb  <= 1'b0;
            shreg     <= '0;
            sh_lsb    <= 1'b0;
            cnt       <= '0;
            par_bit   <= 1'b0;
            ser_out   <= IDLE_LEVEL;
            ser_en    <= 1'b0;
            ser_last  <= 1'b0;
            ser_par   <= 1'b0;
        end else begin
            if (take) begin
                hold_data <= in_if.in_data;
                hold_lsb  <= in_if.in_lsb_first;
            end
            hold_full <= take || (hold_full && !load_now);

            if (load_now) begin
                state    <= S_SHIFT;
                shreg    <= hold_data;
                sh_lsb   <= hold_lsb;
                cnt      <= '0;
                par_bit  <= ^hold_data;
                ser_en   <= 1'b1;
                ser_out  <= hold_lsb ? hold_data[0] : hold_data[WIDTH-1];
                ser_last <= 1'b0;
                ser_par  <= 1'b0;
            end else if (state == S_SHIFT) begin
                if (ser_last) begin
                    state    <= S_IDLE;
                    ser_en   <= 1'b0;
                    ser_out  <= IDLE_LEVEL;
                    ser_last <= 1'b0;
                    ser_par  <= 1'b0;
                end else begin
                    cnt      <= cnt_nxt;
                    shreg    <= sh_lsb ? (shreg >> 1) : (shreg << 1);
                    ser_last <= (cnt_nxt == CW'(FRAME_LEN - 1));
                    ser_par  <= (cnt_nxt == CW'(WIDTH));
                    if (cnt_nxt == CW'(WIDTH))
                        ser_out <= par_bit;
                    else
                        ser_out <= sh_lsb ? shreg[1] : shreg[WIDTH-2];
                end
            end
        end
    end
`else
    assign ser_par = 1'b0;

    // Frame sequencer: load from holding register, shift one bit per clock toward the output end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            hold_full <= 1'b0;
            hold_data <= '0;
            hold_lsb  <= 1'b0;
            shreg     <= '0;
            sh_lsb    <= 1'b0;
            cnt       <= '0;
            ser_out   <= IDLE_LEVEL;
            ser_en    <= 1'b0;
            ser_last  <= 1'b0;
        end else begin
            if (take) begin
                hold_data <= in_if.in_data;
                hold_lsb  <= in_if.in_lsb_first;
            end
            hold_full <= take || (hold_full && !load_now);

            if (load_now) begin
                state    <= S_SHIFT;
                shreg    <= hold_data;
                sh_lsb   <= hold_lsb;
                cnt      <= '0;
                ser_en   <= 1'b1;
                ser_out  <= hold_lsb ? hold_data[0] : hold_data[WIDTH-1];
                ser_last <= 1'b0;
            end else if (state == S_SHIFT) begin
                if (ser_last) begin
                    state    <= S_IDLE;
                    ser_en   <= 1'b0;
                    ser_out  <= IDLE_LEVEL;
                    ser_last <= 1'b0;
                end else begin
                    cnt      <= cnt_nxt;
                    shreg    <= sh_lsb ? (shreg >> 1) : (shreg << 1);
                    ser_last <= (cnt_nxt == CW'(FRAME_LEN - 1));
                    ser_out  <= sh_lsb ? shreg[1] : shreg[WIDTH-2];
                end
            end
        end
    end
`endif

endmodule
